// File: rtl/cpu_defs.sv
// Shared exception definitions: CP0 exception codes, the exception vector,
// the exception-unit state encoding and the record captured for one event.
package cpu_defs;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Bit positions inside m_exc_flags = {adel_if, ri, ov, sys, bp, adel_ld, ades}
  localparam int FLAG_ADEL_IF = 6;
  localparam int FLAG_RI      = 5;
  localparam int FLAG_OV      = 4;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_BP      = 2;
  localparam int FLAG_ADEL_LD = 1;
  localparam int FLAG_ADES    = 0;

  typedef enum logic [1:0] {
    EXC_IDLE     = 2'd0,
    EXC_HOLD     = 2'd1,
    EXC_REDIRECT = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic        is_exc;
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bv_wen;
    logic [31:0] bv_data;
    logic [31:0] target;
  } exc_rec_t;

  function automatic logic needs_badvaddr(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Combinational exception priority encoder: picks the single winning cause
// among the pending interrupt and the memory-stage fault flags.
module exc_prio
  import cpu_defs::*;
(
  input  logic [6:0] i_flags,
  input  logic       i_int,
  output logic [4:0] o_code,
  output logic       o_hit
);

  always_comb begin
    o_hit  = 1'b1;
    o_code = EXC_INT;
    if (i_int) begin
      o_code = EXC_INT;
    end else if (i_flags[FLAG_ADEL_IF]) begin
      o_code = EXC_ADEL;
    end else if (i_flags[FLAG_RI]) begin
      o_code = EXC_RI;
    end else if (i_flags[FLAG_OV]) begin
      o_code = EXC_OV;
    end else if (i_flags[FLAG_SYS]) begin
      o_code = EXC_SYS;
    end else if (i_flags[FLAG_BP]) begin
      o_code = EXC_BP;
    end else if (i_flags[FLAG_ADEL_LD]) begin
      o_code = EXC_ADEL;
    end else if (i_flags[FLAG_ADES]) begin
      o_code = EXC_ADES;
    end else begin
      o_hit  = 1'b0;
      o_code = EXC_INT;
    end
  end

endmodule

// File: rtl/exc_unit.sv
// Memory-stage exception/ERET commit unit: commits one event to CP0, flushes
// younger stages and holds a fetch redirect until fetch accepts it.
module exc_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        m_stall,
  input  logic [31:0] m_pc,
  input  logic        m_in_ds,
  input  logic [6:0]  m_exc_flags,
  input  logic [31:0] m_badvaddr,
  input  logic        m_eret,
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  output logic        is_valid_exc,
  output logic [31:0] epc_wdata,
  output logic        cause_bd_wdata,
  output logic [4:0]  cause_exccode_wdata,
  output logic        badvaddr_wen,
  output logic [31:0] badvaddr_wdata,
  output logic        eret_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  exc_state_e  r_state;
  exc_state_e  w_next_state;
  logic        r_int_pending;
  exc_rec_t    r_held;
  exc_rec_t    w_now;
  exc_rec_t    w_src;
  logic        w_commit;
  logic        w_prio_hit;
  logic [4:0]  w_prio_code;
  logic        w_is_exc;
  logic        w_event;
  logic [31:0] w_epc_calc;
  logic        w_unused;

  // CP0 register bits outside IE/EXL/IM/IP are not consumed here
  assign w_unused = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

  exc_prio u_exc_prio (
    .i_flags (m_exc_flags),
    .i_int   (r_int_pending),
    .o_code  (w_prio_code),
    .o_hit   (w_prio_hit)
  );

  assign w_is_exc   = m_valid & w_prio_hit;
  assign w_event    = m_valid & (w_prio_hit | m_eret);
  assign w_epc_calc = m_in_ds ? (m_pc - 32'd4) : m_pc;

  always_comb begin
    w_now         = '0;
    w_now.is_exc  = w_is_exc;
    w_now.is_eret = m_valid & m_eret & ~w_prio_hit;
    if (w_is_exc) begin
      w_now.code   = w_prio_code;
      w_now.epc    = w_epc_calc;
      w_now.bd     = m_in_ds;
      w_now.bv_wen = needs_badvaddr(w_prio_code);
    end
    // Fetch faults report the instruction's own PC as the bad address
    if (w_now.bv_wen) begin
      w_now.bv_data = (m_exc_flags[FLAG_ADEL_IF] & ~r_int_pending) ? m_pc : m_badvaddr;
    end
    w_now.target = w_is_exc ? EXC_VECTOR : epc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= EXC_IDLE;
      r_int_pending <= 1'b0;
      r_held        <= '0;
    end else begin
      r_state       <= w_next_state;
      r_int_pending <= status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
      if ((r_state == EXC_IDLE) && w_event) begin
        r_held <= w_now;
      end
    end
  end

  always_comb begin
    w_next_state        = r_state;
    w_commit            = 1'b0;
    w_src               = w_now;
    is_valid_exc        = 1'b0;
    eret_commit         = 1'b0;
    epc_wdata           = '0;
    cause_bd_wdata      = 1'b0;
    cause_exccode_wdata = '0;
    badvaddr_wen        = 1'b0;
    badvaddr_wdata      = '0;
    flush               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    if (!rst) begin
      case (r_state)
        EXC_IDLE: begin
          if (w_event) begin
            if (m_stall) begin
              w_next_state = EXC_HOLD;
            end else begin
              w_commit     = 1'b1;
              w_src        = w_now;
              w_next_state = EXC_REDIRECT;
            end
          end
        end
        EXC_HOLD: begin
          if (!m_stall) begin
            w_commit     = 1'b1;
            w_src        = r_held;
            w_next_state = EXC_REDIRECT;
          end
        end
        EXC_REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = r_held.target;
          flush          = 1'b1;
          if (redirect_ready) begin
            w_next_state = EXC_IDLE;
          end
        end
        default: w_next_state = EXC_IDLE;
      endcase
      if (w_commit) begin
        is_valid_exc        = w_src.is_exc;
        eret_commit         = w_src.is_eret;
        epc_wdata           = w_src.epc;
        cause_bd_wdata      = w_src.bd;
        cause_exccode_wdata = w_src.code;
        badvaddr_wen        = w_src.bv_wen;
        badvaddr_wdata      = w_src.bv_data;
        flush               = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
// Scoreboard bench for exc_unit: a driver issues memory-stage transactions and
// queues model predictions; a negedge monitor pops and compares them.
module tb_exc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic        m_stall;
  logic [31:0] m_pc;
  logic        m_in_ds;
  logic [6:0]  m_exc_flags;
  logic [31:0] m_badvaddr;
  logic        m_eret;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        is_valid_exc;
  logic [31:0] epc_wdata;
  logic        cause_bd_wdata;
  logic [4:0]  cause_exccode_wdata;
  logic        badvaddr_wen;
  logic [31:0] badvaddr_wdata;
  logic        eret_commit;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  typedef struct {
    bit          isExc;
    bit          isEret;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    bit          bvWen;
    logic [31:0] bvData;
  } commit_t;

  localparam logic [31:0] VECTOR = 32'hBFC0_0380;

  // Cause codes in priority order for flag bits 6 down to 0
  logic [4:0] prioCode [0:6] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

  commit_t     commitQ[$];
  logic [31:0] redirectQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          tbMonitorOn = 1'b0;
  bit          tbExpectCommit = 1'b0;
  bit          tbExpectRedirect = 1'b0;
  commit_t     monExp;
  logic [31:0] monPc;

  exc_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .m_valid             (m_valid),
    .m_stall             (m_stall),
    .m_pc                (m_pc),
    .m_in_ds             (m_in_ds),
    .m_exc_flags         (m_exc_flags),
    .m_badvaddr          (m_badvaddr),
    .m_eret              (m_eret),
    .status              (status),
    .cause               (cause),
    .epc                 (epc),
    .is_valid_exc        (is_valid_exc),
    .epc_wdata           (epc_wdata),
    .cause_bd_wdata      (cause_bd_wdata),
    .cause_exccode_wdata (cause_exccode_wdata),
    .badvaddr_wen        (badvaddr_wen),
    .badvaddr_wdata      (badvaddr_wdata),
    .eret_commit         (eret_commit),
    .flush               (flush),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .redirect_ready      (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic commit_t modelCommit(input bit valid, input logic [6:0] flags, input bit intP,
                                          input bit eret, input logic [31:0] pc, input bit inDs,
                                          input logic [31:0] badv);
    commit_t c;
    int win;
    c = '{default: 0};
    win = -1;
    for (int i = 0; i < 7; i++) begin
      if (win < 0 && flags[6-i]) win = i;
    end
    c.isExc  = valid && (intP || win >= 0);
    c.isEret = valid && eret && !c.isExc;
    if (c.isExc) begin
      c.code   = intP ? 5'h00 : prioCode[win];
      c.epc    = inDs ? pc - 32'd4 : pc;
      c.bd     = inDs;
      c.bvWen  = !intP && (c.code == 5'h04 || c.code == 5'h05);
      c.bvData = (!intP && win == 0) ? pc : badv;
    end
    return c;
  endfunction

  // Monitor: per-cycle handshake expectations plus queued payload checks
  always @(negedge clk) begin
    if (tbMonitorOn) begin
      checkOutput("commitStrobe", 32'(is_valid_exc | eret_commit), 32'(tbExpectCommit));
      checkOutput("excEretExclusive", 32'(is_valid_exc & eret_commit), 32'd0);
      checkOutput("flush", 32'(flush), 32'(tbExpectCommit | tbExpectRedirect));
      checkOutput("redirectValid", 32'(redirect_valid), 32'(tbExpectRedirect));
      if (is_valid_exc || eret_commit) begin
        if (commitQ.size() == 0) begin
          checkOutput("unexpectedCommit", 32'd1, 32'd0);
        end else begin
          monExp = commitQ.pop_front();
          checkOutput("isValidExc", 32'(is_valid_exc), 32'(monExp.isExc));
          checkOutput("eretCommit", 32'(eret_commit), 32'(monExp.isEret));
          checkOutput("badvaddrWen", 32'(badvaddr_wen), 32'(monExp.bvWen));
          if (monExp.isExc) begin
            checkOutput("excCode", 32'(cause_exccode_wdata), 32'(monExp.code));
            checkOutput("epcWdata", epc_wdata, monExp.epc);
            checkOutput("causeBd", 32'(cause_bd_wdata), 32'(monExp.bd));
          end
          if (monExp.bvWen) checkOutput("badvaddrData", badvaddr_wdata, monExp.bvData);
        end
      end
      if (redirect_valid) begin
        if (redirectQ.size() == 0) begin
          checkOutput("unexpectedRedirect", 32'd1, 32'd0);
        end else begin
          checkOutput("redirectPc", redirect_pc, redirectQ[0]);
          if (redirect_ready) monPc = redirectQ.pop_front();
        end
      end
    end
  end

  task automatic applyStimulus(input bit valid, input logic [6:0] flags, input bit eret,
                               input logic [31:0] pc, input bit inDs, input logic [31:0] badv,
                               input logic [31:0] statusV, input logic [31:0] causeV,
                               input logic [31:0] epcV, input int stallCycles, input int readyDelay);
    commit_t exp;
    bit intP;
    bit isEvent;
    status = statusV;
    cause = causeV;
    epc = epcV;
    m_valid = 1'b0;
    m_stall = 1'b0;
    m_exc_flags = '0;
    m_eret = 1'b0;
    redirect_ready = 1'b0;
    tick();
    intP = statusV[0] && !statusV[1] && ((causeV[15:8] & statusV[15:8]) != 8'h00);
    exp = modelCommit(valid, flags, intP, eret, pc, inDs, badv);
    isEvent = exp.isExc || exp.isEret;
    m_valid = valid;
    m_exc_flags = flags;
    m_eret = eret;
    m_pc = pc;
    m_in_ds = inDs;
    m_badvaddr = badv;
    m_stall = (stallCycles > 0);
    repeat (stallCycles) tick();
    m_stall = 1'b0;
    tbExpectCommit = isEvent;
    if (isEvent) begin
      commitQ.push_back(exp);
      redirectQ.push_back(exp.isExc ? VECTOR : epcV);
    end
    tick();
    tbExpectCommit = 1'b0;
    m_valid = 1'b0;
    m_pc = $urandom;
    m_exc_flags = 7'($urandom);
    m_badvaddr = $urandom;
    m_in_ds = 1'($urandom);
    m_eret = 1'($urandom);
    epc = $urandom;
    if (isEvent) begin
      tbExpectRedirect = 1'b1;
      repeat (readyDelay) tick();
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      tbExpectRedirect = 1'b0;
    end
  endtask

  task automatic checkResetMidRedirect();
    tbMonitorOn = 1'b0;
    status = 32'h0;
    cause = 32'h0;
    m_valid = 1'b0;
    tick();
    m_valid = 1'b1;
    m_exc_flags = 7'b0010000;
    m_eret = 1'b0;
    m_pc = 32'h8000_5000;
    tick();
    m_valid = 1'b0;
    redirect_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstPreRedirectValid", 32'(redirect_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstRedirectValid", 32'(redirect_valid), 32'd0);
    checkOutput("rstRedirectPc", redirect_pc, 32'd0);
    checkOutput("rstFlush", 32'(flush), 32'd0);
    checkOutput("rstStrobes", 32'({is_valid_exc, eret_commit, badvaddr_wen}), 32'd0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstStaysIdle", 32'(redirect_valid | flush), 32'd0);
    tick();
    tbMonitorOn = 1'b1;
  endtask

  initial begin
    logic [31:0] statusV;
    logic [31:0] causeV;
    logic [6:0]  flags;
    int r;
    rst = 1'b1;
    m_valid = 1'b0;
    m_stall = 1'b0;
    m_pc = '0;
    m_in_ds = 1'b0;
    m_exc_flags = '0;
    m_badvaddr = '0;
    m_eret = 1'b0;
    status = '0;
    cause = '0;
    epc = '0;
    redirect_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetStrobes", 32'({is_valid_exc, eret_commit, badvaddr_wen, flush, redirect_valid}), 32'd0);
    checkOutput("resetRedirectPc", redirect_pc, 32'd0);
    tick();
    tbMonitorOn = 1'b1;

    applyStimulus(1, 7'b0010000, 0, 32'h8000_1000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 7'b0001000, 0, 32'h8000_2004, 1, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1);
    applyStimulus(1, 7'b0000000, 0, 32'h8000_4000, 0, 32'h0, 32'h0000_0401, 32'h0000_0400, 32'h0, 0, 0);
    applyStimulus(1, 7'b0000000, 0, 32'h8000_4008, 0, 32'h0, 32'h0000_0403, 32'h0000_0400, 32'h0, 0, 0);
    applyStimulus(1, 7'b0100001, 0, 32'h8000_4010, 0, 32'h1, 32'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 7'b1000000, 0, 32'h8000_4021, 0, 32'h5, 32'h0, 32'h0, 32'h0, 1, 0);
    applyStimulus(1, 7'b0000001, 0, 32'h8000_4030, 0, 32'h3, 32'h0, 32'h0, 32'h0, 0, 2);
    applyStimulus(1, 7'b0000000, 1, 32'h8000_4040, 0, 32'h0, 32'h0, 32'h0, 32'h8000_3000, 0, 4);
    applyStimulus(1, 7'b0000100, 1, 32'h8000_4050, 0, 32'h0, 32'h0, 32'h0, 32'h8000_3000, 2, 1);
    applyStimulus(0, 7'b0010000, 1, 32'h8000_4060, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    checkResetMidRedirect();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) flags = 7'h00;
      else if (r < 7) flags = 7'(7'b1 << $urandom_range(0, 6));
      else flags = 7'($urandom);
      statusV = {16'h0, 8'($urandom), 6'h0, 1'($urandom_range(0, 3) == 0), 1'($urandom)};
      causeV = {16'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 8'h00};
      applyStimulus($urandom_range(0, 9) != 0, flags, $urandom_range(0, 3) == 0,
                    {16'h8000, 14'($urandom), 2'b00}, 1'($urandom), $urandom,
                    statusV, causeV, $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    repeat (2) tick();
    tbMonitorOn = 1'b0;
    checkOutput("commitQueueDrained", 32'(commitQ.size()), 32'd0);
    checkOutput("redirectQueueDrained", 32'(redirectQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
